// File: rtl/priority_enc_pkg.sv
// Shared constants for the 4-to-2 priority encoder slice.
// The encoder width is fixed: four request lines, two-bit index.
package priority_enc_pkg;

    // Number of request inputs; the encoder is written for exactly four.
    localparam int unsigned N_IN  = 4;

    // Encoded index width, clog2(N_IN).
    localparam int unsigned OUT_W = 2;

    // Index reported when no request is granted; only meaningful with valid=0.
    localparam logic [OUT_W-1:0] IDX_NONE = 2'b00;

endpackage : priority_enc_pkg

// File: rtl/priority_encoder_4_to_2_core.sv
// Combinational core of the 4-to-2 priority encoder.
// The highest-numbered asserted request wins; request 3 has top priority.
// With enable low, or with no request asserted, the core reports no hit.
module priority_encoder_4_to_2_core
    import priority_enc_pkg::*;
(
    input  logic [N_IN-1:0]  in,
    input  logic             enable,
    output logic [OUT_W-1:0] idx,
    output logic             hit
);

    // Explicit priority chain: the first matching pattern from the top bit down decides.
    always_comb begin
        idx = IDX_NONE;
        hit = 1'b0;
        if (enable) begin
            casez (in)
                4'b1???: begin
                    idx = 2'b11;
                    hit = 1'b1;
                end
                4'b01??: begin
                    idx = 2'b10;
                    hit = 1'b1;
                end
                4'b001?: begin
                    idx = 2'b01;
                    hit = 1'b1;
                end
                4'b0001: begin
                    idx = 2'b00;
                    hit = 1'b1;
                end
                4'b0000: begin
                    idx = IDX_NONE;
                    hit = 1'b0;
                end
                default: begin
                    // Only reachable with undriven request bits; report no grant.
                    idx = IDX_NONE;
                    hit = 1'b0;
                end
            endcase
        end else begin
            idx = IDX_NONE;
            hit = 1'b0;
        end
    end

endmodule : priority_encoder_4_to_2_core

// File: rtl/priority_encoder_4_to_2.sv
// 4-input priority encoder with active-high enable and a registered output.
// out carries the index of the highest asserted request one clock after it
// is sampled; valid qualifies out, since index 00 alone is ambiguous.
module priority_encoder_4_to_2
    import priority_enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_IN-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    logic [OUT_W-1:0] idx_s;
    logic             hit_s;
    logic [OUT_W-1:0] out_r;
    logic             valid_r;

    priority_encoder_4_to_2_core u_core (
        .in     (in),
        .enable (enable),
        .idx    (idx_s),
        .hit    (hit_s)
    );

    // Output register: cleared asynchronously by reset, otherwise loads the
    // core result every edge (the core already forces no-hit when disabled).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r   <= IDX_NONE;
            valid_r <= 1'b0;
        end else begin
            out_r   <= idx_s;
            valid_r <= hit_s;
        end
    end

    assign out   = out_r;
    assign valid = valid_r;

endmodule : priority_encoder_4_to_2

// File: tb/tb_priority_encoder_4_to_2.sv
// Directed, table-driven bench for the 4-to-2 priority encoder.
module tb_priority_encoder_4_to_2;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [1:0] exp_out;
        logic       exp_valid;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] in_s;
    logic [1:0] out_s;
    logic       valid_s;

    int n_cmp;
    int n_err;

    vec_t vecs[$];

    priority_encoder_4_to_2 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .in     (in_s),
        .out    (out_s),
        .valid  (valid_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: scan from the top bit down, first set bit wins.
    function automatic logic [2:0] ref_model(input logic en, input logic [3:0] v);
        logic [2:0] r;
        logic       found;
        r = 3'b000;
        found = 1'b0;
        if (en) begin
            for (int i = 3; i >= 0; i--) begin
                if (v[i] && !found) begin
                    found = 1'b1;
                    r = {1'b1, 2'(i)};
                end
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [1:0] act_out, input logic act_valid,
                         input logic [1:0] exp_out, input logic exp_valid);
        n_cmp++;
        if (act_out !== exp_out || act_valid !== exp_valid) begin
            n_err++;
            $display("FAIL %s: got out=%b valid=%b, expected out=%b valid=%b",
                     name, act_out, act_valid, exp_out, exp_valid);
        end
    endtask

    // Drive one sampled pair away from the edge, then check after the edge.
    task automatic step(input logic en, input logic [3:0] v);
        @(negedge clk);
        enable = en;
        in_s   = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] m;
        n_cmp = 0;
        n_err = 0;

        // Hand-computed vectors: full sweep, priority masking, enable handling.
        vecs.push_back('{1'b1, 4'b0000, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 4'b0001, 2'b00, 1'b1});
        vecs.push_back('{1'b1, 4'b0010, 2'b01, 1'b1});
        vecs.push_back('{1'b1, 4'b0011, 2'b01, 1'b1});
        vecs.push_back('{1'b1, 4'b0100, 2'b10, 1'b1});
        vecs.push_back('{1'b1, 4'b0101, 2'b10, 1'b1});
        vecs.push_back('{1'b1, 4'b0110, 2'b10, 1'b1});
        vecs.push_back('{1'b1, 4'b0111, 2'b10, 1'b1});
        vecs.push_back('{1'b1, 4'b1000, 2'b11, 1'b1});
        vecs.push_back('{1'b1, 4'b1001, 2'b11, 1'b1});
        vecs.push_back('{1'b1, 4'b1010, 2'b11, 1'b1});
        vecs.push_back('{1'b1, 4'b1011, 2'b11, 1'b1});
        vecs.push_back('{1'b1, 4'b1100, 2'b11, 1'b1});
        vecs.push_back('{1'b1, 4'b1101, 2'b11, 1'b1});
        vecs.push_back('{1'b1, 4'b1110, 2'b11, 1'b1});
        vecs.push_back('{1'b1, 4'b1111, 2'b11, 1'b1});
        vecs.push_back('{1'b1, 4'b1001, 2'b11, 1'b1});
        vecs.push_back('{1'b1, 4'b0110, 2'b10, 1'b1});
        vecs.push_back('{1'b1, 4'b0011, 2'b01, 1'b1});
        vecs.push_back('{1'b0, 4'b1111, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 4'b1111, 2'b11, 1'b1});
        vecs.push_back('{1'b0, 4'b0001, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 4'b0100, 2'b10, 1'b1});
        vecs.push_back('{1'b0, 4'b0010, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 4'b0001, 2'b00, 1'b1});

        // Reset asserted with every request active: outputs clear immediately.
        rst_n  = 1'b0;
        enable = 1'b1;
        in_s   = 4'b1111;
        #1;
        check("reset_immediate", out_s, valid_s, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_1", out_s, valid_s, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_2", out_s, valid_s, 2'b00, 1'b0);

        // Release between edges; the first edge after release samples normally.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_release", out_s, valid_s, 2'b11, 1'b1);

        // Table-driven vectors, each also checked against the reference model.
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].req);
            check($sformatf("vec%0d_en%b_in%b", i, vecs[i].en, vecs[i].req),
                  out_s, valid_s, vecs[i].exp_out, vecs[i].exp_valid);
            m = ref_model(vecs[i].en, vecs[i].req);
            check($sformatf("model%0d", i), out_s, valid_s, m[1:0], m[2]);
        end

        // Asynchronous reset pulse mid-run, entirely between two edges.
        step(1'b1, 4'b1111);
        check("pre_pulse", out_s, valid_s, 2'b11, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("pulse_clears", out_s, valid_s, 2'b00, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        check("pulse_released_no_edge", out_s, valid_s, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        check("resume_after_pulse", out_s, valid_s, 2'b11, 1'b1);
        step(1'b1, 4'b0010);
        check("resume_next", out_s, valid_s, 2'b01, 1'b1);

        // Enable and request change together: the sampled pair decides.
        step(1'b0, 4'b1000);
        check("toggle_off", out_s, valid_s, 2'b00, 1'b0);
        step(1'b1, 4'b0101);
        check("toggle_on", out_s, valid_s, 2'b10, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_priority_encoder_4_to_2
